// File: rtl/regfile_mp_if.sv
// Bundle of read ports, both write ports and status for regfile_mp.
// master drives addresses/writes, slave is the register file.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic                  wb_we;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  aux_we;
    logic [AW-1:0]         aux_addr;
    logic [XLEN-1:0]       aux_data;
    logic                  ready;
    logic                  collision;

    modport master (
        output rd_addr, wb_we, wb_addr, wb_data,
        output aux_we, aux_addr, aux_data,
        input  rd_data, ready, collision
    );

    modport slave (
        input  rd_addr, wb_we, wb_addr, wb_data,
        input  aux_we, aux_addr, aux_data,
        output rd_data, ready, collision
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: WB + aux write ports, N read ports,
// fixed WB priority, collision flag and a post-reset scrub of every entry.
module regfile_mp #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 32,
    parameter int NREAD   = 2,
    parameter int BYPASS  = 1,
    parameter int SP_IDX  = 2,
    parameter int SP_INIT = 1020,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    typedef enum logic {SCRUB, RUN} state_t;

    localparam logic [XLEN-1:0] SPV  = XLEN'(SP_INIT);
    localparam logic [AW-1:0]   SPA  = AW'(SP_IDX);
    localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

    state_t          state, state_nx;
    logic [AW-1:0]   ptr, ptr_nx;
    logic            coll_q, coll_nx;
    logic [XLEN-1:0] mem [DEPTH];
    logic            run, same, wb_ok, aux_ok;

    assign run    = (state == RUN);
    assign same   = (bus.wb_addr == bus.aux_addr);
    assign wb_ok  = run && bus.wb_we && (bus.wb_addr != '0);
    // WB wins an address clash, so aux only commits when WB is elsewhere
    assign aux_ok = run && bus.aux_we && (bus.aux_addr != '0)
                    && !(bus.wb_we && same);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        coll_nx  = 1'b0;
        unique case (state)
            SCRUB: begin
                ptr_nx = ptr + 1'b1;
                if (ptr == LAST) state_nx = RUN;
            end
            RUN: coll_nx = wb_ok && bus.aux_we && same;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SCRUB;
            ptr    <= '0;
            coll_q <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            coll_q <= coll_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem[ptr] <= (ptr == SPA) ? SPV : '0;
            end else begin
                if (wb_ok)  mem[bus.wb_addr]  <= bus.wb_data;
                if (aux_ok) mem[bus.aux_addr] <= bus.aux_data;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;

        assign ra = bus.rd_addr[k*AW +: AW];

        always_comb begin
            rv = mem[ra];
            if (!run || ra == '0)
                rv = '0;
            else if (BYPASS != 0 && bus.wb_we && bus.wb_addr == ra)
                rv = bus.wb_data;
            else if (BYPASS != 0 && bus.aux_we && bus.aux_addr == ra)
                rv = bus.aux_data;
        end

        assign bus.rd_data[k*XLEN +: XLEN] = rv;
    end

    assign bus.ready     = run;
    assign bus.collision = coll_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: BYPASS=1 and BYPASS=0 instances share stimulus
// and are checked every cycle against an array-level model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   chk_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .AW(5), .NREAD(2)) bus1 ();
    regfile_mp_if #(.XLEN(32), .AW(5), .NREAD(2)) bus0 ();

    assign bus0.rd_addr  = bus1.rd_addr;
    assign bus0.wb_we    = bus1.wb_we;
    assign bus0.wb_addr  = bus1.wb_addr;
    assign bus0.wb_data  = bus1.wb_data;
    assign bus0.aux_we   = bus1.aux_we;
    assign bus0.aux_addr = bus1.aux_addr;
    assign bus0.aux_data = bus1.aux_data;

    regfile_mp #(.BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    regfile_mp #(.BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Model: after 32 released edges the file holds 0 everywhere but SP.
    int          mcnt;
    bit          mready;
    bit          mcoll;
    logic [31:0] mmem [32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt   <= 0;
            mready <= 1'b0;
            mcoll  <= 1'b0;
        end else if (!mready) begin
            mcnt  <= mcnt + 1;
            mcoll <= 1'b0;
            if (mcnt == 31) begin
                mready <= 1'b1;
                for (int i = 0; i < 32; i++)
                    mmem[i] <= (i == 2) ? 32'd1020 : 32'd0;
            end
        end else begin
            mcoll <= bus1.wb_we && bus1.aux_we && bus1.wb_addr == bus1.aux_addr
                     && bus1.wb_addr != 5'd0;
            if (bus1.aux_we && bus1.aux_addr != 5'd0
                && !(bus1.wb_we && bus1.wb_addr == bus1.aux_addr))
                mmem[bus1.aux_addr] <= bus1.aux_data;
            if (bus1.wb_we && bus1.wb_addr != 5'd0)
                mmem[bus1.wb_addr] <= bus1.wb_data;
        end
    end

    function automatic logic [31:0] exp_rd(logic [4:0] a, bit byp);
        if (!mready || a == 5'd0) return 32'd0;
        if (byp && bus1.wb_we && bus1.wb_addr == a) return bus1.wb_data;
        if (byp && bus1.aux_we && bus1.aux_addr == a) return bus1.aux_data;
        return mmem[a];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("byp1_rd%0d", k), 64'(bus1.rd_data[k*32 +: 32]),
                      64'(exp_rd(bus1.rd_addr[k*5 +: 5], 1'b1)));
                check($sformatf("byp0_rd%0d", k), 64'(bus0.rd_data[k*32 +: 32]),
                      64'(exp_rd(bus1.rd_addr[k*5 +: 5], 1'b0)));
            end
            check("byp1_ready", 64'(bus1.ready), 64'(mready));
            check("byp0_ready", 64'(bus0.ready), 64'(mready));
            check("byp1_coll", 64'(bus1.collision), 64'(mcoll));
            check("byp0_coll", 64'(bus0.collision), 64'(mcoll));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd,
                         logic ae, logic [4:0] aa, logic [31:0] ad,
                         logic [4:0] r0, logic [4:0] r1);
        bus1.wb_we    = we;
        bus1.wb_addr  = wa;
        bus1.wb_data  = wd;
        bus1.aux_we   = ae;
        bus1.aux_addr = aa;
        bus1.aux_data = ad;
        bus1.rd_addr  = {r1, r0};
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // 1: scrub length and contents
        repeat (31) step();
        check("t1_ready_31", 64'(bus1.ready), 64'd0);
        step();
        check("t1_ready_32", 64'(bus1.ready), 64'd1);
        check("t1_model_sp", 64'(exp_rd(5'd2, 1'b1)), 64'd1020);
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            #1;
            check($sformatf("t1_rd%0d", a), 64'(bus1.rd_data[31:0]),
                  (a == 2) ? 64'd1020 : 64'd0);
        end
        step();

        // 2: same-cycle bypass vs next-cycle visibility
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        #1;
        check("t2_byp1", 64'(bus1.rd_data[31:0]), 64'hDEADBEEF);
        check("t2_byp0_old", 64'(bus0.rd_data[31:0]), 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 5, 5);
        #1;
        check("t2_byp1_next", 64'(bus1.rd_data[63:32]), 64'hDEADBEEF);
        check("t2_byp0_next", 64'(bus0.rd_data[31:0]), 64'hDEADBEEF);
        check("t2_model_m5", 64'(mmem[5]), 64'hDEADBEEF);
        step();

        // 3: same-address collision, WB wins
        drive(1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 7);
        #1;
        check("t3_byp_wb", 64'(bus1.rd_data[31:0]), 64'h11111111);
        check("t3_coll_pre", 64'(bus1.collision), 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        check("t3_coll1", 64'(bus1.collision), 64'd1);
        check("t3_coll0", 64'(bus0.collision), 64'd1);
        #1;
        check("t3_val", 64'(bus0.rd_data[31:0]), 64'h11111111);
        step();
        check("t3_coll_end", 64'(bus1.collision), 64'd0);

        // 4: distinct addresses both commit
        drive(1, 8, 32'hA5A5A5A5, 1, 9, 32'h5A5A5A5A, 8, 9);
        step();
        drive(0, 0, 0, 0, 0, 0, 8, 9);
        #1;
        check("t4_wb", 64'(bus0.rd_data[31:0]), 64'hA5A5A5A5);
        check("t4_aux", 64'(bus0.rd_data[63:32]), 64'h5A5A5A5A);
        check("t4_coll", 64'(bus1.collision), 64'd0);
        step();

        // 5: x0 is hardwired zero even on the bypass path
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0);
        #1;
        check("t5_rd0", 64'(bus1.rd_data[31:0]), 64'd0);
        check("t5_rd1", 64'(bus1.rd_data[63:32]), 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_coll", 64'(bus1.collision), 64'd0);
        step();

        // 6: reset mid-scrub restarts it; writes during scrub ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #2;
        drive(1, 5, 32'h00001234, 1, 5, 32'h00005678, 5, 2);
        step();
        rst = 1'b0;
        repeat (31) step();
        check("t6_ready_31", 64'(bus1.ready), 64'd0);
        check("t6_coll", 64'(bus1.collision), 64'd0);
        step();
        check("t6_ready_32", 64'(bus1.ready), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 2, 5);
        #1;
        check("t6_sp", 64'(bus1.rd_data[31:0]), 64'd1020);
        check("t6_m5", 64'(bus0.rd_data[63:32]), 64'd0);
        step();
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
